// File: rtl/flash_pkg.sv
// Shared definitions for the SPI flash read arbiter.
// Holds the READ opcode, the transaction field widths, the arbiter state type
// and the byte-order helper used when a received word is handed back.
package flash_pkg;

   localparam logic [7:0]  FLASH_CMD_READ = 8'h03;

   localparam int unsigned CMD_BITS  = 8;
   localparam int unsigned ADDR_BITS = 24;
   localparam int unsigned DATA_BITS = 32;
   localparam int unsigned HDR_BITS  = CMD_BITS + ADDR_BITS;
   localparam int unsigned XFER_BITS = HDR_BITS + DATA_BITS;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGap
   } state_e;

   // The flash streams bytes in ascending address order; the first byte on the
   // wire lands in the shift register's top byte, but belongs in data[7:0].
   function automatic logic [DATA_BITS-1:0] le_bytes(input logic [DATA_BITS-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shift engine for one fixed-length flash READ transaction.
//
// Ports:
//   sys_clk, sys_reset - system clock, synchronous active-high reset
//   start              - one-cycle strobe; latches hdr and opens a transaction
//   hdr                - {opcode, address} shifted out MSB first
//   miso               - serial data from the flash
//   done               - high in the cycle whose edge ends the last SCK period
//   data               - received data word, first byte in data[7:0]
//   cs_n, sck, mosi    - registered flash pins
//
// Every SCK half-period lasts CLK_DIV cycles. mosi only moves on falling SCK
// edges (or at start, while SCK is still low), and miso is sampled on the edge
// that raises SCK. The data phase shifts out zeros.
module spi_shift_engine
   import flash_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic                 sys_clk,
   input  logic                 sys_reset,
   input  logic                 start,
   input  logic [HDR_BITS-1:0]  hdr,
   input  logic                 miso,
   output logic                 done,
   output logic [DATA_BITS-1:0] data,
   output logic                 cs_n,
   output logic                 sck,
   output logic                 mosi
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [6:0] BIT_LAST = 7'(XFER_BITS - 1);

   logic                 active_q, active_d;
   logic                 cs_n_q, cs_n_d;
   logic                 sck_q, sck_d;
   logic                 mosi_q, mosi_d;
   logic [7:0]           div_q, div_d;
   logic [6:0]           bit_q, bit_d;
   logic [XFER_BITS-2:0] out_q, out_d;
   logic [DATA_BITS-1:0] in_q, in_d;
   logic                 half_end;

   assign half_end = (div_q == DIV_LAST);
   assign done     = active_q && sck_q && half_end && (bit_q == BIT_LAST);
   assign data     = le_bytes(in_q);
   assign cs_n     = cs_n_q;
   assign sck      = sck_q;
   assign mosi     = mosi_q;

   always_comb begin
      active_d = active_q;
      cs_n_d   = cs_n_q;
      sck_d    = sck_q;
      mosi_d   = mosi_q;
      div_d    = div_q;
      bit_d    = bit_q;
      out_d    = out_q;
      in_d     = in_q;

      if (start) begin
         active_d = 1'b1;
         cs_n_d   = 1'b0;
         sck_d    = 1'b0;
         div_d    = '0;
         bit_d    = '0;
         in_d     = '0;
         // First bit goes out now so it is settled before the first rising edge.
         mosi_d   = hdr[HDR_BITS-1];
         out_d    = {hdr[HDR_BITS-2:0], {DATA_BITS{1'b0}}};
      end else if (active_q) begin
         if (half_end) begin
            div_d = '0;
            if (!sck_q) begin
               sck_d = 1'b1;
               in_d  = {in_q[DATA_BITS-2:0], miso};
            end else begin
               sck_d = 1'b0;
               bit_d = bit_q + 7'd1;
               if (bit_q == BIT_LAST) begin
                  active_d = 1'b0;
                  cs_n_d   = 1'b1;
                  mosi_d   = 1'b0;
               end else begin
                  mosi_d = out_q[XFER_BITS-2];
                  out_d  = {out_q[XFER_BITS-3:0], 1'b0};
               end
            end
         end else begin
            div_d = div_q + 8'd1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         active_q <= 1'b0;
         cs_n_q   <= 1'b1;
         sck_q    <= 1'b0;
         mosi_q   <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         out_q    <= '0;
         in_q     <= '0;
      end else begin
         active_q <= active_d;
         cs_n_q   <= cs_n_d;
         sck_q    <= sck_d;
         mosi_q   <= mosi_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         out_q    <= out_d;
         in_q     <= in_d;
      end
   end

endmodule

// File: rtl/flash_read_arbiter.sv
// Two-port arbiter sharing one SPI flash for 32-bit READ (0x03) transactions.
//
// Ports:
//   sys_clk, sys_reset          - system clock, synchronous active-high reset
//   req0_valid/req0_addr        - CPU fetch request, held until rsp0_valid
//   rsp0_valid/rsp0_data        - one-cycle response pulse and word for port 0
//   req1_valid/req1_addr        - UART loader/debug request
//   rsp1_valid/rsp1_data        - response for port 1
//   busy                        - high from grant until the cs_n idle gap ends
//   flash_spi_*                 - flash pins; wp_n and hold_n tied inactive
//
// A grant in IDLE starts the shift engine; its done strobe returns the word to
// the granted port, after which cs_n is held high for CS_IDLE cycles before the
// next arbitration. Ties alternate, starting with port 0 after reset.
module flash_read_arbiter
   import flash_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned CS_IDLE = 4
) (
   input  logic                 sys_clk,
   input  logic                 sys_reset,
   input  logic                 req0_valid,
   input  logic [ADDR_BITS-1:0] req0_addr,
   output logic                 rsp0_valid,
   output logic [DATA_BITS-1:0] rsp0_data,
   input  logic                 req1_valid,
   input  logic [ADDR_BITS-1:0] req1_addr,
   output logic                 rsp1_valid,
   output logic [DATA_BITS-1:0] rsp1_data,
   output logic                 busy,
   output logic                 flash_spi_cs_n,
   output logic                 flash_spi_clk,
   output logic                 flash_spi_mosi,
   input  logic                 flash_spi_miso,
   output logic                 flash_spi_wp_n,
   output logic                 flash_spi_hold_n
);

   localparam logic [7:0] GAP_LAST = 8'(CS_IDLE - 1);

   state_e               state_q, state_d;
   logic [7:0]           gap_q, gap_d;
   logic                 rr_last_q, rr_last_d;
   logic                 owner_q, owner_d;
   logic                 rsp0_valid_q, rsp0_valid_d;
   logic                 rsp1_valid_q, rsp1_valid_d;
   logic [DATA_BITS-1:0] rsp0_data_q, rsp0_data_d;
   logic [DATA_BITS-1:0] rsp1_data_q, rsp1_data_d;

   logic                 any_req;
   logic                 gnt_port;
   logic                 start;
   logic [HDR_BITS-1:0]  hdr;
   logic                 eng_done;
   logic [DATA_BITS-1:0] eng_data;

   // ---------------------------------------------------------------- state
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         state_q <= StIdle;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      unique case (state_q)
         StIdle: begin
            if (req0_valid || req1_valid) begin
               state_d = StShift;
            end
         end
         StShift: begin
            if (eng_done) begin
               state_d = StGap;
               gap_d   = '0;
            end
         end
         StGap: begin
            if (gap_q == GAP_LAST) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      any_req  = req0_valid || req1_valid;
      // On a tie take the port that was not served last; otherwise the lone requester.
      gnt_port = (req0_valid && req1_valid) ? ~rr_last_q : req1_valid;
      start    = (state_q == StIdle) && any_req;
      hdr      = {FLASH_CMD_READ, (gnt_port ? req1_addr : req0_addr)};
      busy     = (state_q != StIdle);

      rr_last_d = start ? gnt_port : rr_last_q;
      owner_d   = start ? gnt_port : owner_q;

      rsp0_valid_d = eng_done && !owner_q;
      rsp1_valid_d = eng_done && owner_q;
      rsp0_data_d  = rsp0_valid_d ? eng_data : rsp0_data_q;
      rsp1_data_d  = rsp1_valid_d ? eng_data : rsp1_data_q;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         rr_last_q    <= 1'b1;
         owner_q      <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
      end else begin
         rr_last_q    <= rr_last_d;
         owner_q      <= owner_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp1_data_q  <= rsp1_data_d;
      end
   end

   assign rsp0_valid       = rsp0_valid_q;
   assign rsp1_valid       = rsp1_valid_q;
   assign rsp0_data        = rsp0_data_q;
   assign rsp1_data        = rsp1_data_q;
   assign flash_spi_wp_n   = 1'b1;
   assign flash_spi_hold_n = 1'b1;

   spi_shift_engine #(
      .CLK_DIV (CLK_DIV)
   ) u_engine (
      .sys_clk   (sys_clk),
      .sys_reset (sys_reset),
      .start     (start),
      .hdr       (hdr),
      .miso      (flash_spi_miso),
      .done      (eng_done),
      .data      (eng_data),
      .cs_n      (flash_spi_cs_n),
      .sck       (flash_spi_clk),
      .mosi      (flash_spi_mosi)
   );

endmodule
